fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode/control stage. It owns the PC and issues
//  one word request at a time on the instruction bus (addr_ok/data_ok split handshake). It presents
//  {pc, instr} to decode through a one-entry valid/ready buffer and applies branch redirects from decode.
// PARAMETERS
//  RESET_PC    32'hbfc0_0000   first fetch address after reset
// PORTS
//  clk            in   1   sole clock; all state updates on posedge
//  resetn         in   1   asynchronous, active-low reset
//  ireq_valid     out  1   fetch request valid; held until iresp_addr_ok
//  ireq_addr      out  32  fetch address; stable while ireq_valid=1
//  iresp_addr_ok  in   1   request accepted this cycle
//  iresp_data_ok  in   1   data returned this cycle; may coincide with addr_ok
//  iresp_data     in   32  instruction word, valid with data_ok
//  redirect_valid in   1   one-cycle pulse: decode resolved a taken branch or jump
//  redirect_pc    in   32  branch target
//  out_valid      out  1   {out_pc, out_instr} holds a fetched instruction
//  out_pc         out  32  PC of out_instr
//  out_instr      out  32  instruction word sent to decode
//  out_ready      in   1   decode consumes the entry when out_valid & out_ready
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, ireq_valid=0, ireq_addr=0, out_valid=0, out_pc=0,
//   out_instr=0, redir_pend=0.
//  FSM (fetch_state_t):
//   IDLE   issue when the buffer is free: buffer empty, or out_ready=1 this cycle -> REQ.
//   REQ    ireq_valid=1 with ireq_addr=pc.
//          addr_ok & data_ok -> CAPTURE, and go to IDLE or REQ by the IDLE rule.
//          addr_ok only -> WAIT.
//   WAIT   ireq_valid=0. data_ok -> CAPTURE, then IDLE or REQ by the IDLE rule.
//  CAPTURE (same edge as data_ok):
//   - out_pc <= pc, out_instr <= iresp_data, out_valid <= 1.
//   - pc <= redir_pend ? redir_tgt : pc+4. redir_pend clears.
//   - Capture is legal only when the buffer is free; the issue rule guarantees this.
//  Buffer: out_valid clears on out_valid & out_ready unless a capture happens in the same cycle.
//   A capture in that cycle overwrites the entry and keeps out_valid=1.
//   Fetch-to-out_valid latency with zero-wait memory is 2 cycles (REQ cycle, then registered output).
//  Redirect (delay-slot semantics): the word in flight, or the next word fetched, is the delay slot
//   and is always delivered. redirect_valid latches redir_pend=1 and redir_tgt=redirect_pc.
//   - Redirect in IDLE with no outstanding fetch: pc+4 was already committed, so the delay slot is
//     the next fetch. pc is still updated at that capture, so the target follows it.
//   - Redirect on the same edge as a capture: the captured word is the branch's delay slot, so
//     pc <= redirect_pc directly and redir_pend stays 0.
//   - A second redirect while redir_pend=1 overwrites the pending target (last wins).
//  PC arithmetic is 32-bit unsigned. pc+4 wraps from 32'hffff_fffc to 0 without a flag.
//  ireq_addr must not change while in REQ, including when a redirect arrives.
//  Reset assertion mid-transaction aborts at once. A late data_ok arriving after reset is
//   ignored because the FSM is in IDLE.
// CONFIGURATION
//  FETCH_ADDR_ERR_EN defined:
//   - In IDLE, a pc with pc[1:0]!=0 issues no bus request.
//   - It captures directly with out_instr=32'h0 (nop) and drives extra output out_addr_err=1
//     (out_addr_err is present only under this macro).
//   - pc then advances as for a normal capture.
//  FETCH_ADDR_ERR_EN undefined: the out_addr_err port is absent, pc[1:0] is ignored, and
//   every pc is fetched on the bus.
// STRUCTURE
//  Shared header mycpu/fetch.svh holds:
//   - fetch_state_t enum {IDLE, REQ, WAIT}
//   - RESET_PC default constant
//   - fetch_out_t struct {pc, instr, addr_err}
//  One sub-module, fetch_out_buf: the one-entry valid/ready register with load/consume/overwrite.
//   The FSM and PC logic stay in fetch_unit.
// TESTING
//  1 Reset, zero-wait memory (addr_ok & data_ok same cycle), out_ready=1 ->
//    out_pc 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive issues; first out_valid 2 cycles after reset release.
//  2 addr_ok at cycle t, data_ok at t+3 -> ireq_valid drops at t+1 and ireq_addr is stable during REQ;
//    one outstanding request only.
//  3 out_ready=0 for 5 cycles with out_valid=1 -> no new ireq_valid.
//    On release, the entry is consumed and the next fetch issues that same cycle.
//  4 redirect_valid pulse to 0xbfc00100 while fetching 0xbfc00010 (delay slot) ->
//    out_pc sequence 0xbfc00010, 0xbfc00100.
//  5 Redirect in IDLE after capturing 0xbfc00020 -> next out_pc 0xbfc00024 (delay slot), then the target.
//  6 resetn low during WAIT, then a stray data_ok -> out_valid stays 0; first fetch after release is RESET_PC.
//    With FETCH_ADDR_ERR_EN, redirect to 0xbfc00102 -> no bus request, out_instr=0, out_addr_err=1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//                fetch_state_t - fetch FSM states (IDLE, REQ, WAIT)
//                fetch_out_t   - one entry of the decode-facing buffer
//                c_RESET_PC    - default first fetch address after reset
//                pc_inc()      - sequential PC step (32-bit wrap, no flag)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam logic [31:0] c_RESET_PC = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        addr_err;
  } fetch_out_t;

  // Sequential successor; wraps from 32'hffff_fffc to 0 silently.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_out_buf
//  Description : One-entry valid/ready register between fetch and decode.
//                A load always wins: it overwrites the entry and keeps
//                valid set, even when the old entry is consumed on the same
//                edge. Without a load, valid clears on valid & ready.
//  Ports       : clk, resetn        - clock, asynchronous active-low reset
//                load_i, load_*_i   - write a new entry this edge
//                ready_i            - consumer accepts the current entry
//                valid_o, pc_o, instr_o, err_o - registered entry contents
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_instr_i,
  input  logic        load_err_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic       valid_q;
  fetch_out_t entry_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (load_i) begin
      valid_q          <= 1'b1;
      entry_q.pc       <= load_pc_i;
      entry_q.instr    <= load_instr_i;
      entry_q.addr_err <= load_err_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = entry_q.pc;
  assign instr_o = entry_q.instr;
  assign err_o   = entry_q.addr_err;

endmodule : fetch_out_buf
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues one word
//                request at a time on a split addr_ok/data_ok bus, hands
//                {pc, instr} to decode through fetch_out_buf and applies
//                delay-slot branch redirects from decode.
//  Parameters  : RESET_PC - first fetch address after reset
//  Macro       : FETCH_ADDR_ERR_EN - misaligned PCs are not fetched; a nop
//                is delivered with out_addr_err=1 (port exists only then).
//  Ports       : clk, resetn                     - clock, async low reset
//                ireq_valid, ireq_addr           - fetch request
//                iresp_addr_ok, iresp_data_ok,
//                iresp_data                      - bus response
//                redirect_valid, redirect_pc     - taken branch from decode
//                out_valid, out_pc, out_instr,
//                out_ready                       - decode handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef FETCH_ADDR_ERR_EN
  ,
  output logic        out_addr_err
`endif
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         redir_pend_q;
  logic [31:0]  redir_tgt_q;
  logic         ireq_valid_q;
  logic [31:0]  ireq_addr_q;

  logic         w_out_valid;
  logic         w_buf_err;
  logic         w_buf_free;
  logic         w_bus_capture;
  logic         w_err_capture;
  logic         w_capture;
  logic         w_misaligned;
  logic         w_next_misaligned;
  logic         w_issue_after_capture;
  logic [31:0]  w_load_instr;

  // The buffer can take a word on the next edge if it is empty now or
  // its current entry is being consumed on that edge.
  assign w_buf_free = !w_out_valid || out_ready;

`ifdef FETCH_ADDR_ERR_EN
  assign w_misaligned      = (pc_q[1:0] != 2'b00);
  assign w_next_misaligned = (pc_d[1:0] != 2'b00);
  assign out_addr_err      = w_buf_err;
`else
  logic w_unused_addr_err;
  assign w_misaligned      = 1'b0;
  assign w_next_misaligned = 1'b0;
  assign w_unused_addr_err = w_buf_err;
`endif

  // Bus data lands in the buffer on the data_ok edge.
  always_comb begin
    w_bus_capture = 1'b0;
    case (state_q)
      REQ:     w_bus_capture = iresp_addr_ok && iresp_data_ok;
      WAIT:    w_bus_capture = iresp_data_ok;
      default: w_bus_capture = 1'b0;
    endcase
  end

  // A misaligned PC is delivered as a nop straight from IDLE.
  assign w_err_capture = (state_q == IDLE) && w_misaligned && w_buf_free;
  assign w_capture     = w_bus_capture || w_err_capture;
  assign w_load_instr  = w_err_capture ? 32'h0 : iresp_data;

  // PC moves only when a word is captured. A redirect on the capture edge
  // makes the captured word its delay slot, so the target is taken at once;
  // otherwise a pending target (from an earlier redirect) takes effect here.
  always_comb begin
    pc_d = pc_q;
    if (w_capture) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else if (redir_pend_q) begin
        pc_d = redir_tgt_q;
      end else begin
        pc_d = pc_inc(pc_q);
      end
    end
  end

  // After a capture the buffer holds the new word, so the next request is
  // issued straight away only while decode is still accepting.
  assign w_issue_after_capture = out_ready && !w_next_misaligned;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= 32'h0;
    end else begin
      pc_q <= pc_d;

      if (w_capture) begin
        redir_pend_q <= 1'b0;
      end else if (redirect_valid) begin
        // Last redirect wins while one is already pending.
        redir_pend_q <= 1'b1;
        redir_tgt_q  <= redirect_pc;
      end

      case (state_q)
        IDLE: begin
          if (w_buf_free && !w_misaligned) begin
            state_q      <= REQ;
            ireq_valid_q <= 1'b1;
            ireq_addr_q  <= pc_q;
          end
        end
        REQ: begin
          // ireq_addr_q is untouched until the request is accepted.
          if (iresp_addr_ok) begin
            if (iresp_data_ok && w_issue_after_capture) begin
              state_q     <= REQ;
              ireq_addr_q <= pc_d;
            end else if (iresp_data_ok) begin
              state_q      <= IDLE;
              ireq_valid_q <= 1'b0;
            end else begin
              state_q      <= WAIT;
              ireq_valid_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (iresp_data_ok) begin
            if (w_issue_after_capture) begin
              state_q      <= REQ;
              ireq_valid_q <= 1'b1;
              ireq_addr_q  <= pc_d;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          ireq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = ireq_addr_q;

  fetch_out_buf u_out_buf (
    .clk          (clk),
    .resetn       (resetn),
    .load_i       (w_capture),
    .load_pc_i    (pc_q),
    .load_instr_i (w_load_instr),
    .load_err_i   (w_err_capture),
    .ready_i      (out_ready),
    .valid_o      (w_out_valid),
    .pc_o         (out_pc),
    .instr_o      (out_instr),
    .err_o        (w_buf_err)
  );

  assign out_valid = w_out_valid;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: a cycle table for the
//                directed scenarios, hand sequences for reset/wrap (and the
//                FETCH_ADDR_ERR_EN path when that macro is defined), then a
//                random phase scored against a queue of expected deliveries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
`ifdef FETCH_ADDR_ERR_EN
  logic        out_addr_err;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
`ifdef FETCH_ADDR_ERR_EN
    ,
    .out_addr_err   (out_addr_err)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] acc_addr = 32'h0;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives the inputs seen at the next posedge; the bus returns memf() of
  // the most recently accepted address.
  task automatic drive(input logic aok, input logic dok, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    if (aok) acc_addr = ireq_addr;
    iresp_addr_ok  = aok;
    iresp_data_ok  = dok;
    iresp_data     = dok ? memf(acc_addr) : 32'hdead_beef;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  typedef struct packed {
    logic        e_iv;
    logic [31:0] e_ia;
    logic        e_ov;
    logic [31:0] e_pc;
    logic        aok;
    logic        dok;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic ov,
                              input logic [31:0] pc, input logic aok, input logic dok,
                              input logic rdy, input logic rv, input logic [31:0] rpc);
    vec_t v;
    v.e_iv = iv; v.e_ia = ia; v.e_ov = ov; v.e_pc = pc;
    v.aok = aok; v.dok = dok; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction

  vec_t tbl[31];

  initial begin
    // Each row: expected outputs at this negedge, then inputs for the next edge.
    tbl[0]  = mk(0, 0,            0, 0,            0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 32'hbfc00000, 0, 0,            1, 1, 1, 0, 0);
    tbl[2]  = mk(1, 32'hbfc00004, 1, 32'hbfc00000, 1, 1, 1, 0, 0);
    tbl[3]  = mk(1, 32'hbfc00008, 1, 32'hbfc00004, 1, 1, 1, 0, 0);
    tbl[4]  = mk(1, 32'hbfc0000c, 1, 32'hbfc00008, 1, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0,            0, 0,            0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0,            0, 0,            0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0,            0, 0,            0, 1, 1, 0, 0);
    tbl[8]  = mk(1, 32'hbfc00010, 1, 32'hbfc0000c, 1, 0, 1, 1, 32'hbfc00100);
    tbl[9]  = mk(0, 0,            0, 0,            0, 1, 1, 0, 0);
    tbl[10] = mk(1, 32'hbfc00100, 1, 32'hbfc00010, 1, 1, 1, 0, 0);
    tbl[11] = mk(1, 32'hbfc00104, 1, 32'hbfc00100, 1, 0, 1, 0, 0);
    tbl[12] = mk(0, 0,            0, 0,            0, 1, 0, 0, 0);
    tbl[13] = mk(0, 0,            1, 32'hbfc00104, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0,            1, 32'hbfc00104, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0,            1, 32'hbfc00104, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0,            1, 32'hbfc00104, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0,            1, 32'hbfc00104, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0,            1, 32'hbfc00104, 0, 0, 1, 0, 0);
    tbl[19] = mk(1, 32'hbfc00108, 0, 0,            1, 1, 1, 0, 0);
    tbl[20] = mk(1, 32'hbfc0010c, 1, 32'hbfc00108, 1, 0, 1, 0, 0);
    tbl[21] = mk(0, 0,            0, 0,            0, 1, 0, 0, 0);
    tbl[22] = mk(0, 0,            1, 32'hbfc0010c, 0, 0, 0, 1, 32'hbfc00200);
    tbl[23] = mk(0, 0,            1, 32'hbfc0010c, 0, 0, 1, 0, 0);
    tbl[24] = mk(1, 32'hbfc00110, 0, 0,            1, 1, 1, 0, 0);
    tbl[25] = mk(1, 32'hbfc00200, 1, 32'hbfc00110, 1, 1, 1, 1, 32'hbfc00300);
    tbl[26] = mk(1, 32'hbfc00300, 1, 32'hbfc00200, 1, 1, 1, 0, 0);
    tbl[27] = mk(1, 32'hbfc00304, 1, 32'hbfc00300, 0, 0, 1, 1, 32'hbfc00400);
    tbl[28] = mk(1, 32'hbfc00304, 0, 0,            0, 0, 1, 1, 32'hbfc00500);
    tbl[29] = mk(1, 32'hbfc00304, 0, 0,            1, 1, 1, 0, 0);
    tbl[30] = mk(1, 32'hbfc00500, 1, 32'hbfc00304, 0, 0, 1, 0, 0);

    // ---------------- reset state ----------------
    @(negedge clk);
    chk("rst ireq_valid", {31'b0, ireq_valid}, 32'd0);
    chk("rst ireq_addr", ireq_addr, 32'h0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_pc", out_pc, 32'h0);
    chk("rst out_instr", out_instr, 32'h0);
    resetn = 1'b1;

    // ---------------- directed cycle table ----------------
    for (int i = 0; i < 31; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("r%0d ireq_valid", i), {31'b0, ireq_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].e_iv) chk($sformatf("r%0d ireq_addr", i), ireq_addr, tbl[i].e_ia);
      chk($sformatf("r%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      if (tbl[i].e_ov) begin
        chk($sformatf("r%0d out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("r%0d out_instr", i), out_instr, memf(tbl[i].e_pc));
`ifdef FETCH_ADDR_ERR_EN
        chk($sformatf("r%0d out_addr_err", i), {31'b0, out_addr_err}, 32'd0);
`endif
      end
      drive(tbl[i].aok, tbl[i].dok, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
    end

    // ---------------- reset during WAIT, stray data_ok ----------------
    @(negedge clk);
    drive(1, 0, 1, 0, 0);                       // request for 0xbfc00500 accepted
    @(negedge clk);
    chk("wait ireq_valid", {31'b0, ireq_valid}, 32'd0);
    drive(0, 0, 1, 0, 0);
    #2 resetn = 1'b0;
    #1;
    chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("async rst ireq_addr", ireq_addr, 32'h0);
    @(negedge clk);
    drive(0, 1, 1, 0, 0);                       // stray data_ok
    @(negedge clk);
    resetn = 1'b1;                              // data_ok still high after release
    @(negedge clk);
    chk("post-rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("post-rst ireq_valid", {31'b0, ireq_valid}, 32'd1);
    chk("post-rst ireq_addr", ireq_addr, RST_PC);

    // ---------------- PC wrap-around ----------------
    drive(1, 1, 1, 1, 32'hffff_fffc);
    @(negedge clk);
    chk("wrap out_pc0", out_pc, RST_PC);
    chk("wrap addr0", ireq_addr, 32'hffff_fffc);
    drive(1, 1, 1, 0, 0);
    @(negedge clk);
    chk("wrap out_pc1", out_pc, 32'hffff_fffc);
    chk("wrap out_instr1", out_instr, memf(32'hffff_fffc));
    chk("wrap addr1", ireq_addr, 32'h0);

`ifdef FETCH_ADDR_ERR_EN
    // ---------------- misaligned PC ----------------
    drive(1, 1, 1, 1, 32'hbfc0_0102);
    @(negedge clk);
    chk("err no request", {31'b0, ireq_valid}, 32'd0);
    chk("err prev flag", {31'b0, out_addr_err}, 32'd0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("err out_valid", {31'b0, out_valid}, 32'd1);
    chk("err out_pc", out_pc, 32'hbfc0_0102);
    chk("err out_instr", out_instr, 32'h0);
    chk("err flag", {31'b0, out_addr_err}, 32'd1);
    chk("err still no request", {31'b0, ireq_valid}, 32'd0);
    drive(0, 0, 1, 1, 32'hbfc0_0200);
    @(negedge clk);
    chk("err2 out_pc", out_pc, 32'hbfc0_0106);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("err recover request", {31'b0, ireq_valid}, 32'd1);
    chk("err recover addr", ireq_addr, 32'hbfc0_0200);
`endif

    // ---------------- random phase ----------------
    drive(0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    begin
      logic [31:0] expq[$];
      logic [31:0] exp_pc = RST_PC;
      logic        mpend = 1'b0;
      logic [31:0] mtgt = 32'h0;
      logic        pend_n = 1'b0;
      int          wcnt = 0;
      logic        hold_v = 1'b0;
      logic [31:0] hold_a = 32'h0;
      int          consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic        aok, dok, rdy, rv;
        logic [31:0] rpc, e;
        int          lat;
        if (cyc != 0) @(negedge clk);
        if (pend_n) chk("one outstanding", {31'b0, ireq_valid}, 32'd0);
        if (ireq_valid && hold_v) chk("ireq_addr stable", ireq_addr, hold_a);

        aok = 1'b0;
        dok = 1'b0;
        if (pend_n) begin
          if (wcnt == 0) begin
            dok    = 1'b1;
            pend_n = 1'b0;
          end else begin
            wcnt--;
          end
        end else if (ireq_valid && ($urandom_range(0, 1) == 1)) begin
          aok = 1'b1;
          lat = $urandom_range(0, 3);
          if (lat == 0) dok = 1'b1;
          else begin
            pend_n = 1'b1;
            wcnt   = lat - 1;
          end
        end
        // Decode keeps accepting whenever a word lands, so no entry is lost.
        rdy = dok | ($urandom_range(0, 3) != 0);
        rv  = ($urandom_range(0, 7) == 0);
        rpc = {16'hbfc0, 14'($urandom), 2'b00};

        hold_v = ireq_valid && !aok;
        hold_a = ireq_addr;
        drive(aok, dok, rdy, rv, rpc);

        if (out_valid && rdy) begin
          consumed++;
          if (expq.size() == 0) begin
            chk("consume without capture", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("rand out_pc", out_pc, e);
            chk("rand out_instr", out_instr, memf(e));
          end
        end

        // Delivery order: each captured word is the current PC; a redirect
        // takes effect after the next captured word (its delay slot).
        if (dok) begin
          expq.push_back(exp_pc);
          if (rv)         exp_pc = rpc;
          else if (mpend) exp_pc = mtgt;
          else            exp_pc = exp_pc + 32'd4;
          mpend = 1'b0;
        end else if (rv) begin
          mpend = 1'b1;
          mtgt  = rpc;
        end
      end
      chk("rand progress", {31'b0, (consumed > 200)}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
